// File: rtl/uart_fifo_bridge_pkg.sv
// rtl/uart_fifo_bridge_pkg.sv - shared constants and FSM encodings for the UART FIFO bridge
package uart_fifo_bridge_pkg;

  localparam int FIFO_DEPTH_LOG2 = 3;
  localparam int FIFO_DEPTH      = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LAUNCH    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// rtl/uart_fifo_bridge_if.sv - CPU register side and UART core side signals of the bridge
interface uart_fifo_bridge_if
  import uart_fifo_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
);

  logic [7:0]          tx_wdata;
  logic                tx_we;
  logic                tx_full;
  logic [DEPTH_LOG2:0] tx_count;
  logic [7:0]          rx_rdata;
  logic                rx_re;
  logic                rx_empty;
  logic [DEPTH_LOG2:0] rx_count;
  logic                rx_overrun;
  logic                ovr_clr;
  logic [7:0]          u_din;
  logic                u_start;
  logic                u_busy;
  logic [7:0]          u_dout;
  logic                u_has_byte;
  logic                u_clr_hb;

  modport slave (
    input  tx_wdata, tx_we, rx_re, ovr_clr, u_busy, u_dout, u_has_byte,
    output tx_full, tx_count, rx_rdata, rx_empty, rx_count, rx_overrun,
    output u_din, u_start, u_clr_hb
  );

  modport master (
    output tx_wdata, tx_we, rx_re, ovr_clr, u_busy, u_dout, u_has_byte,
    input  tx_full, tx_count, rx_rdata, rx_empty, rx_count, rx_overrun,
    input  u_din, u_start, u_clr_hb
  );

endinterface

// File: rtl/uart_fifo_bridge_byte_fifo.sv
// rtl/uart_fifo_bridge_byte_fifo.sv - show-ahead circular byte FIFO with occupancy counter
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          wdata,
  input  logic                we,
  output logic [7:0]          rdata,
  input  logic                re,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == DEPTH_CNT);
  assign empty   = (cnt == '0);
  assign do_push = we && !full;
  assign do_pop  = re && !empty;
  assign count   = cnt;
  // Head reads as zero when empty so stale storage never leaks out.
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (DEPTH_LOG2 + 1)'(1);
        2'b01:   cnt <= cnt - (DEPTH_LOG2 + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - TX/RX byte FIFOs with launch and acknowledge FSMs toward a UART core
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input logic               clk,
  input logic               rst,
  uart_fifo_bridge_if.slave bus
);

  logic [7:0]          tx_head;
  logic                tx_empty;
  logic                tx_full;
  logic                tx_pop;
  logic [DEPTH_LOG2:0] tx_count;

  logic [7:0]          rx_head;
  logic                rx_empty;
  logic                rx_full;
  logic                rx_push;
  logic                rx_drop;
  logic                rx_capture;
  logic [DEPTH_LOG2:0] rx_count;

  tx_state_e  tx_state;
  tx_state_e  tx_next;
  logic [7:0] din_q;
  logic       start_q;

  rx_state_e rx_state;
  rx_state_e rx_next;
  logic      clr_q;
  logic      ovr_q;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (bus.tx_wdata),
    .we    (bus.tx_we),
    .rdata (tx_head),
    .re    (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (bus.u_dout),
    .we    (rx_push),
    .rdata (rx_head),
    .re    (bus.rx_re),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      din_q    <= 8'h00;
      start_q  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      start_q  <= tx_pop;
      if (tx_pop) din_q <= tx_head;
    end
  end

  // Waiting for busy to rise before waiting for it to fall guarantees one start per frame.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !bus.u_busy) begin
          tx_pop  = 1'b1;
          tx_next = TX_LAUNCH;
        end
      end
      TX_LAUNCH:    tx_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (bus.u_busy) tx_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!bus.u_busy) tx_next = TX_IDLE;
      default:      tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      clr_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rx_state <= rx_next;
      clr_q    <= rx_capture;
      if (rx_drop)          ovr_q <= 1'b1;
      else if (bus.ovr_clr) ovr_q <= 1'b0;
    end
  end

  // RX_ACK ignores has_byte for one cycle: the UART still shows the byte just taken.
  always_comb begin
    rx_next    = rx_state;
    rx_capture = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (bus.u_has_byte) begin
          rx_capture = 1'b1;
          rx_next    = RX_ACK;
        end
      end
      RX_ACK:  rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  assign rx_push = rx_capture && !rx_full;
  assign rx_drop = rx_capture && rx_full;

  assign bus.tx_full    = tx_full;
  assign bus.tx_count   = tx_count;
  assign bus.rx_rdata   = rx_head;
  assign bus.rx_empty   = rx_empty;
  assign bus.rx_count   = rx_count;
  assign bus.rx_overrun = ovr_q;
  assign bus.u_din      = din_q;
  assign bus.u_start    = start_q;
  assign bus.u_clr_hb   = clr_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - randomized bench with queue-based reference model and UART environment
module tb_uart_fifo_bridge;
  import uart_fifo_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_fifo_bridge_if #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) bus ();

  uart_fifo_bridge #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  bit         m_ovr, m_clr, frame_open;
  logic [7:0] last_din;
  int         n_starts, clr_pulses;

  // UART environment
  bit         env_busy, env_hb, hold_busy, rx_gap;
  logic [7:0] env_dout;
  logic [7:0] rx_pend[$];
  int         dly, bcnt, busy_len;

  // knobs for the next edge
  bit         k_we, k_re, k_oc, k_rst;
  logic [7:0] k_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    logic [7:0] exp_b;
    if (bus.u_start) begin
      chk("start_while_busy", 32'(bus.u_busy), 32'd0);
      chk("start_in_open_frame", 32'(frame_open), 32'd0);
      chk("start_with_queue", 32'(tx_q.size() > 0), 32'd1);
      if (tx_q.size() > 0) begin
        exp_b = tx_q.pop_front();
        chk("u_din_at_start", 32'(bus.u_din), 32'(exp_b));
      end
      tx_log.push_back(bus.u_din);
      last_din   = bus.u_din;
      n_starts++;
      frame_open = 1'b1;
    end else begin
      chk("u_din_stable", 32'(bus.u_din), 32'(last_din));
    end
    chk("tx_count", 32'(bus.tx_count), 32'(tx_q.size()));
    chk("tx_full", 32'(bus.tx_full), 32'(tx_q.size() == 8));
    chk("rx_count", 32'(bus.rx_count), 32'(rx_q.size()));
    chk("rx_empty", 32'(bus.rx_empty), 32'(rx_q.size() == 0));
    chk("rx_rdata", 32'(bus.rx_rdata), (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'd0);
    chk("rx_overrun", 32'(bus.rx_overrun), 32'(m_ovr));
    chk("u_clr_hb", 32'(bus.u_clr_hb), 32'(m_clr));
  endtask

  task automatic env_update();
    if (bus.u_clr_hb) clr_pulses++;
    if (k_rst) begin
      env_busy = 1'b0; env_hb = 1'b0; env_dout = 8'h00;
      dly = 0; bcnt = 0;
      rx_pend.delete();
    end else begin
      if (bus.u_start) dly = 2;
      else if (dly > 0) begin
        dly--;
        if (dly == 0) begin env_busy = 1'b1; bcnt = busy_len; end
      end else if (env_busy) begin
        bcnt--;
        if (bcnt == 0) begin env_busy = 1'b0; frame_open = 1'b0; end
      end
      if (env_hb && bus.u_clr_hb) env_hb = 1'b0;
      if (!env_hb && rx_pend.size() > 0 && (!rx_gap || $urandom_range(2) == 0)) begin
        env_hb   = 1'b1;
        env_dout = rx_pend.pop_front();
      end
    end
  endtask

  task automatic step();
    bit cap, full_pre;
    rst            = k_rst;
    bus.tx_we      = k_we;
    bus.tx_wdata   = k_wd;
    bus.rx_re      = k_re;
    bus.ovr_clr    = k_oc;
    bus.u_busy     = env_busy || hold_busy;
    bus.u_has_byte = env_hb;
    bus.u_dout     = env_dout;
    if (k_rst) begin
      tx_q.delete(); rx_q.delete();
      m_ovr = 1'b0; m_clr = 1'b0; frame_open = 1'b0; last_din = 8'h00;
    end else begin
      if (k_we && tx_q.size() < 8) tx_q.push_back(k_wd);
      cap      = env_hb && !m_clr;
      full_pre = (rx_q.size() == 8);
      if (k_re && rx_q.size() > 0) void'(rx_q.pop_front());
      if (cap && !full_pre) rx_q.push_back(env_dout);
      if (cap && full_pre) m_ovr = 1'b1;
      else if (k_oc)       m_ovr = 1'b0;
      m_clr = cap;
    end
    @(negedge clk);
    compare();
    env_update();
  endtask

  task automatic idle_knobs();
    k_we = 1'b0; k_wd = 8'h00; k_re = 1'b0; k_oc = 1'b0; k_rst = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget, input string name);
    int n = 0;
    while ((tx_q.size() > 0 || env_busy || dly > 0 || bus.u_start) && n < budget) begin
      step(); n++;
    end
    chk({name, "_tx_drain_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_rx_idle(input int budget, input string name);
    int n = 0;
    while ((rx_pend.size() > 0 || env_hb) && n < budget) begin
      step(); n++;
    end
    chk({name, "_rx_deliver_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int base, n;
    idle_knobs();
    env_busy = 0; env_hb = 0; env_dout = 0; dly = 0; bcnt = 0;
    hold_busy = 0; rx_gap = 0; busy_len = 30;
    m_ovr = 0; m_clr = 0; frame_open = 0; last_din = 0; n_starts = 0; clr_pulses = 0;
    rst = 1'b1;

    k_rst = 1'b1; step(); step(); k_rst = 1'b0;
    chk("rst_tx_count", 32'(bus.tx_count), 32'd0);
    chk("rst_tx_full", 32'(bus.tx_full), 32'd0);
    chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
    chk("rst_rx_rdata", 32'(bus.rx_rdata), 32'd0);
    chk("rst_overrun", 32'(bus.rx_overrun), 32'd0);
    chk("rst_u_start", 32'(bus.u_start), 32'd0);
    chk("rst_u_din", 32'(bus.u_din), 32'd0);
    chk("rst_clr_hb", 32'(bus.u_clr_hb), 32'd0);

    // three back-to-back bytes, divisor 3 frames
    busy_len = 30;
    base = tx_log.size();
    k_we = 1'b1;
    k_wd = 8'h55; step();
    k_wd = 8'hA3; step();
    k_wd = 8'h0F; step();
    idle_knobs();
    wait_tx_idle(400, "t1");
    chk("t1_start_count", 32'(tx_log.size() - base), 32'd3);
    if (tx_log.size() >= base + 3) begin
      chk("t1_byte0", 32'(tx_log[base]), 32'h55);
      chk("t1_byte1", 32'(tx_log[base + 1]), 32'hA3);
      chk("t1_byte2", 32'(tx_log[base + 2]), 32'h0F);
    end
    chk("t1_tx_count", 32'(bus.tx_count), 32'd0);

    // fill past depth while the UART stays busy
    busy_len = 10;
    hold_busy = 1'b1; step();
    for (int i = 0; i < 9; i++) begin
      k_we = 1'b1; k_wd = 8'(8'h80 + i); step();
    end
    idle_knobs();
    chk("t2_tx_count", 32'(bus.tx_count), 32'd8);
    chk("t2_tx_full", 32'(bus.tx_full), 32'd1);
    hold_busy = 1'b0;
    wait_tx_idle(1000, "t2");

    // single received byte
    base = clr_pulses;
    rx_pend.push_back(8'h3C);
    n = 0;
    while (rx_q.size() == 0 && n < 20) begin step(); n++; end
    chk("t3_capture_timeout", 32'(n < 20), 32'd1);
    chk("t3_rx_rdata", 32'(bus.rx_rdata), 32'h3C);
    chk("t3_rx_count", 32'(bus.rx_count), 32'd1);
    chk("t3_rx_empty", 32'(bus.rx_empty), 32'd0);
    repeat (3) step();
    chk("t3_clr_pulses", 32'(clr_pulses - base), 32'd1);
    k_re = 1'b1; step(); k_re = 1'b0;
    chk("t3_rx_empty_after_pop", 32'(bus.rx_empty), 32'd1);
    chk("t3_rx_rdata_after_pop", 32'(bus.rx_rdata), 32'd0);

    // overrun: nine bytes without reads
    for (int i = 0; i < 9; i++) rx_pend.push_back(8'(8'h10 + i));
    wait_rx_idle(200, "t4");
    step(); step();
    chk("t4_overrun", 32'(bus.rx_overrun), 32'd1);
    chk("t4_rx_count", 32'(bus.rx_count), 32'd8);
    chk("t4_rx_head", 32'(bus.rx_rdata), 32'h10);
    k_oc = 1'b1; step(); k_oc = 1'b0;
    chk("t4_overrun_cleared", 32'(bus.rx_overrun), 32'd0);
    rx_pend.push_back(8'hEE);
    step();
    k_oc = 1'b1; step(); k_oc = 1'b0;
    chk("t4_set_beats_clear", 32'(bus.rx_overrun), 32'd1);
    k_re = 1'b1; repeat (10) step(); k_re = 1'b0;
    k_oc = 1'b1; step(); k_oc = 1'b0;

    // has_byte re-raised in the acknowledge cycle
    rx_pend.push_back(8'hA1);
    rx_pend.push_back(8'hB2);
    wait_rx_idle(50, "t5");
    step(); step();
    chk("t5_rx_count", 32'(bus.rx_count), 32'd2);
    chk("t5_first", 32'(bus.rx_rdata), 32'hA1);
    k_re = 1'b1; step(); k_re = 1'b0;
    chk("t5_second", 32'(bus.rx_rdata), 32'hB2);
    k_re = 1'b1; step(); k_re = 1'b0;

    // reset in the middle of a frame
    busy_len = 30;
    for (int i = 0; i < 4; i++) begin
      k_we = 1'b1; k_wd = 8'(8'hC1 + i); step();
    end
    idle_knobs();
    n = 0;
    while (!env_busy && n < 100) begin step(); n++; end
    chk("t6_busy_timeout", 32'(n < 100), 32'd1);
    step(); step();
    chk("t6_pre_count", 32'(bus.tx_count), 32'd3);
    k_rst = 1'b1; step(); k_rst = 1'b0;
    chk("t6_tx_count", 32'(bus.tx_count), 32'd0);
    chk("t6_u_start", 32'(bus.u_start), 32'd0);
    chk("t6_tx_full", 32'(bus.tx_full), 32'd0);
    base = n_starts;
    repeat (50) step();
    chk("t6_no_starts", 32'(n_starts - base), 32'd0);

    // randomized traffic
    rx_gap = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      k_we  = 1'($urandom_range(1));
      k_wd  = 8'($urandom);
      k_re  = ($urandom_range(3) == 0);
      k_oc  = ($urandom_range(15) == 0);
      k_rst = ($urandom_range(499) == 0);
      busy_len = 1 + int'($urandom_range(3));
      if ($urandom_range(2) == 0 && rx_pend.size() < 3) rx_pend.push_back(8'($urandom));
      step();
    end
    idle_knobs();
    rx_gap = 1'b0;
    wait_tx_idle(2000, "rand");
    wait_rx_idle(200, "rand");
    k_re = 1'b1; repeat (10) step(); k_re = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
